mem_controller: RTL and testbench
=================================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4; number of consecutive denied I-side load cycles before I wins arbitration.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 proc2Imem_command  input  2  I-side command; BUS_NONE or BUS_LOAD.
REQ-005 proc2Imem_addr  input  XLEN  I-side address.
REQ-006 proc2Dmem_command  input  2  D-side command; BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-007 proc2Dmem_addr  input  XLEN  D-side address.
REQ-008 proc2Dmem_data  input  64  D-side store data.
REQ-009 mem2proc_response  input  4  memory accept tag; 0 = rejected.
REQ-010 mem2proc_data  input  64  memory return data.
REQ-011 mem2proc_tag  input  4  memory completion tag; 0 = none.
REQ-012 proc2mem_command  output  2  command to memory.
REQ-013 proc2mem_addr  output  XLEN  address to memory.
REQ-014 proc2mem_data  output  64  store data to memory.
REQ-015 d_request  output  1  D side owns the bus this cycle.
REQ-016 Imem2proc_response  output  4  raw mem2proc_response; the icache masks it with d_request.
REQ-017 Imem2proc_data  output  64  mem2proc_data pass-through.
REQ-018 Imem2proc_tag  output  4  completion tag when owned by I, else 0.
REQ-019 Dmem2proc_response  output  4  mem2proc_response when d_request=1, else 0.
REQ-020 Dmem2proc_data  output  64  mem2proc_data pass-through.
REQ-021 Dmem2proc_tag  output  4  completion tag when owned by D, else 0.
REQ-022 outstanding_i  output  4  count of valid table entries owned by I.

Function
REQ-023 Arbitration is combinational, zero latency:
- d_request = (proc2Dmem_command != BUS_NONE) AND NOT (starve_cnt == STARVE_LIMIT AND proc2Imem_command == BUS_LOAD).
REQ-024 Bus mux:
- d_request=1: proc2mem_* = D-side command/addr/data.
- otherwise: command/addr from I side, proc2mem_data = 0.
REQ-025 Starve counter starve_cnt is 3 bits and saturates at STARVE_LIMIT. Per cycle:
- I command == BUS_LOAD and d_request=1: +1.
- otherwise: cleared to 0.
REQ-026 Forced grant: at starve_cnt == STARVE_LIMIT with I load pending, I wins exactly that cycle; the counter then clears.
REQ-027 Ownership table: 16 entries {valid, is_i}, indexed by tag; entry 0 is never valid.
REQ-028 Allocate: proc2mem_command == BUS_LOAD and mem2proc_response != 0 sets valid[response]=1 and is_i[response] = ~d_request on the next edge.
REQ-029 Stores allocate no entry: BUS_STORE acceptance never writes the table.
REQ-030 Complete, routed combinationally from the registered table (pre-update):
- mem2proc_tag != 0 and valid[tag]=1: the tag goes to Imem2proc_tag if is_i, else to Dmem2proc_tag; valid[tag] clears on the next edge.
REQ-031 Completion tag hitting an invalid entry: dropped; Imem2proc_tag = Dmem2proc_tag = 0; no state change.
REQ-032 Same tag allocated and completed in one cycle: the completion routes per the old entry; the allocation wins, and the entry ends valid with the new owner.
REQ-033 Allocating an already-valid tag overwrites the owner; no error is flagged.
REQ-034 outstanding_i = popcount(valid AND is_i) over entries 1..15, taken from registered state.
REQ-035 BUS_NONE on both sides: proc2mem_command = BUS_NONE, d_request=0, and the table is unchanged except for completions.

Reset
REQ-036 While reset=1, on each posedge: all valid bits, is_i bits and starve_cnt clear to 0.
REQ-037 Outputs after reset: outstanding_i=0, Imem2proc_tag=0, Dmem2proc_tag=0.
REQ-038 Reset mid-operation: all outstanding ownership is discarded; later completions of those tags are dropped per REQ-031.

Verification
REQ-039 I load 0x100 alone, response=3 -> d_request=0, proc2mem_addr=0x100; next cycle outstanding_i=1; mem2proc_tag=3 -> Imem2proc_tag=3, Dmem2proc_tag=0, then outstanding_i=0.
REQ-040 I load plus D load in the same cycle, response=5 -> d_request=1, Dmem2proc_response=5, Imem2proc_response=5; tag 5 later -> Dmem2proc_tag=5 only.
REQ-041 D load held for 6 cycles with I load pending (STARVE_LIMIT=4) -> D granted cycles 0-3, I granted cycle 4, D granted cycle 5.
REQ-042 D store accepted with response=7, then mem2proc_tag=7 -> both tag outputs 0, table unchanged.
REQ-043 Tag 2 owned by I; same cycle mem2proc_tag=2 and a D load accepted with response=2 -> Imem2proc_tag=2 this cycle; entry 2 then valid and D-owned; outstanding_i drops by 1.
REQ-044 Two I loads outstanding (tags 1, 4), reset asserted one cycle -> outstanding_i=0; mem2proc_tag=4 afterwards -> Imem2proc_tag=0.

Source files
------------

// File: rtl/mem_controller.sv
// mem_controller
// Arbitrates a single memory port between an instruction-side (I) and a
// data-side (D) requester. D normally wins, but an I load that has been
// denied STARVE_LIMIT consecutive cycles is granted for one cycle. A
// 16-entry ownership table, indexed by the memory's accept/completion
// tag, records which side issued each outstanding load so that
// completions are routed back to the right requester.
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   proc2Imem_command/addr   I-side request (BUS_NONE or BUS_LOAD)
//   proc2Dmem_command/addr/data  D-side request (NONE, LOAD or STORE)
//   mem2proc_response        memory accept tag, 0 = rejected
//   mem2proc_data/tag        memory return data and completion tag
//   proc2mem_command/addr/data   muxed request to memory
//   d_request                D side owns the bus this cycle
//   Imem2proc_*              I-side response/data/completion tag
//   Dmem2proc_*              D-side response/data/completion tag
//   outstanding_i            number of outstanding loads owned by I
module mem_controller #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2Imem_command,
  input  logic [XLEN-1:0] proc2Imem_addr,
  input  logic [1:0]      proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0]     proc2Dmem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic            d_request,
  output logic [3:0]      Imem2proc_response,
  output logic [63:0]     Imem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Dmem2proc_tag,
  output logic [3:0]      outstanding_i
);

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;
  localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);

  logic [2:0]  starve_cnt;
  logic [15:0] valid;
  logic [15:0] is_i;

  logic i_load;
  logic starved;
  logic cpl_hit;
  logic alloc;

  // ---------------------------------------------------------------------
  // Arbitration and bus mux (combinational, zero latency)
  // ---------------------------------------------------------------------
  assign i_load    = (proc2Imem_command == BUS_LOAD);
  assign starved   = (starve_cnt == LIMIT) && i_load;
  assign d_request = (proc2Dmem_command != BUS_NONE) && !starved;

  always_comb begin
    if (d_request) begin
      proc2mem_command = proc2Dmem_command;
      proc2mem_addr    = proc2Dmem_addr;
      proc2mem_data    = proc2Dmem_data;
    end else begin
      proc2mem_command = proc2Imem_command;
      proc2mem_addr    = proc2Imem_addr;
      proc2mem_data    = 64'h0;
    end
  end

  // ---------------------------------------------------------------------
  // Response / data routing
  // ---------------------------------------------------------------------
  // The icache qualifies the raw response with d_request itself.
  assign Imem2proc_response = mem2proc_response;
  assign Dmem2proc_response = d_request ? mem2proc_response : 4'h0;
  assign Imem2proc_data     = mem2proc_data;
  assign Dmem2proc_data     = mem2proc_data;

  // Completions route from the registered table, before this cycle's
  // allocation is applied. Tag 0 and unknown tags are dropped.
  assign cpl_hit       = (mem2proc_tag != 4'h0) && valid[mem2proc_tag];
  assign Imem2proc_tag = (cpl_hit &&  is_i[mem2proc_tag]) ? mem2proc_tag : 4'h0;
  assign Dmem2proc_tag = (cpl_hit && !is_i[mem2proc_tag]) ? mem2proc_tag : 4'h0;

  // Only accepted loads own a tag; stores never enter the table.
  assign alloc = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'h0);

  // ---------------------------------------------------------------------
  // Registered state: starve counter and ownership table
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 3'd0;
      valid      <= 16'h0;
      is_i       <= 16'h0;
    end else begin
      if (i_load && d_request) begin
        if (starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 3'd1;
      end else begin
        starve_cnt <= 3'd0;
      end

      if (cpl_hit)
        valid[mem2proc_tag] <= 1'b0;

      // Placed after the completion clear so a same-tag allocation in the
      // same cycle leaves the entry valid with the new owner.
      if (alloc) begin
        valid[mem2proc_response] <= 1'b1;
        is_i[mem2proc_response]  <= ~d_request;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outstanding I-side loads (entry 0 is never valid, so skip it)
  // ---------------------------------------------------------------------
  always_comb begin
    outstanding_i = 4'h0;
    for (int i = 1; i < 16; i++)
      outstanding_i = outstanding_i + 4'(valid[i] & is_i[i]);
  end

endmodule

// File: tb/tb_mem_controller.sv
module tb_mem_controller;

  localparam int XLEN = 32;
  localparam logic [1:0] NONE  = 2'h0;
  localparam logic [1:0] LOAD  = 2'h1;
  localparam logic [1:0] STORE = 2'h2;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      proc2Imem_command;
  logic [XLEN-1:0] proc2Imem_addr;
  logic [1:0]      proc2Dmem_command;
  logic [XLEN-1:0] proc2Dmem_addr;
  logic [63:0]     proc2Dmem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic            d_request;
  logic [3:0]      Imem2proc_response;
  logic [63:0]     Imem2proc_data;
  logic [3:0]      Imem2proc_tag;
  logic [3:0]      Dmem2proc_response;
  logic [63:0]     Dmem2proc_data;
  logic [3:0]      Dmem2proc_tag;
  logic [3:0]      outstanding_i;

  mem_controller #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .d_request(d_request),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
    .Dmem2proc_tag(Dmem2proc_tag), .outstanding_i(outstanding_i)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  task automatic expect_val(input string name, input logic [63:0] val);
    name_q.push_back(name);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [63:0] act);
    string       nm;
    logic [63:0] ex;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h with no expected value", act);
    end else begin
      nm = name_q.pop_front();
      ex = exp_q.pop_front();
      assert (act === ex) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", nm, act, ex);
    end
  endtask

  task automatic idle();
    proc2Imem_command = NONE;
    proc2Imem_addr    = '0;
    proc2Dmem_command = NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    mem2proc_response = 4'h0;
    mem2proc_data     = '0;
    mem2proc_tag      = 4'h0;
  endtask

  // Advance one cycle; inputs are then changed 1 time unit after the edge
  // and outputs are sampled 2 units after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic exp_grant [6];

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    expect_val("rst_outstanding_i", 64'd0); check(64'(outstanding_i));
    expect_val("rst_Imem_tag", 64'd0);      check(64'(Imem2proc_tag));
    expect_val("rst_Dmem_tag", 64'd0);      check(64'(Dmem2proc_tag));
    expect_val("rst_d_request", 64'd0);     check(64'(d_request));
    expect_val("rst_cmd_none", 64'(NONE));  check(64'(proc2mem_command));

    // I load alone, accepted with tag 3
    tick();
    proc2Imem_command = LOAD; proc2Imem_addr = 32'h100; mem2proc_response = 4'd3;
    settle();
    expect_val("i_only_d_request", 64'd0);    check(64'(d_request));
    expect_val("i_only_addr", 64'h100);       check(64'(proc2mem_addr));
    expect_val("i_only_cmd", 64'(LOAD));      check(64'(proc2mem_command));
    expect_val("i_only_data_zero", 64'd0);    check(proc2mem_data);
    expect_val("i_only_Iresp", 64'd3);        check(64'(Imem2proc_response));
    expect_val("i_only_Dresp", 64'd0);        check(64'(Dmem2proc_response));
    tick(); idle(); settle();
    expect_val("i_only_outstanding", 64'd1);  check(64'(outstanding_i));
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0123_4567;
    settle();
    expect_val("i_cpl_Itag", 64'd3);          check(64'(Imem2proc_tag));
    expect_val("i_cpl_Dtag", 64'd0);          check(64'(Dmem2proc_tag));
    expect_val("i_cpl_Idata", 64'hDEAD_BEEF_0123_4567); check(Imem2proc_data);
    expect_val("i_cpl_Ddata", 64'hDEAD_BEEF_0123_4567); check(Dmem2proc_data);
    tick(); idle(); settle();
    expect_val("i_cpl_outstanding", 64'd0);   check(64'(outstanding_i));

    // I and D load together, accepted with tag 5: D wins
    proc2Imem_command = LOAD; proc2Imem_addr = 32'h200;
    proc2Dmem_command = LOAD; proc2Dmem_addr = 32'h300;
    proc2Dmem_data = 64'h1111_2222_3333_4444; mem2proc_response = 4'd5;
    settle();
    expect_val("both_d_request", 64'd1);      check(64'(d_request));
    expect_val("both_addr", 64'h300);         check(64'(proc2mem_addr));
    expect_val("both_data", 64'h1111_2222_3333_4444); check(proc2mem_data);
    expect_val("both_Dresp", 64'd5);          check(64'(Dmem2proc_response));
    expect_val("both_Iresp", 64'd5);          check(64'(Imem2proc_response));
    tick(); idle(); settle();
    expect_val("both_outstanding", 64'd0);    check(64'(outstanding_i));
    mem2proc_tag = 4'd5;
    settle();
    expect_val("d_cpl_Dtag", 64'd5);          check(64'(Dmem2proc_tag));
    expect_val("d_cpl_Itag", 64'd0);          check(64'(Imem2proc_tag));
    tick(); idle(); tick();

    // Starvation: D held 6 cycles against a pending I load
    exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      proc2Imem_command = LOAD; proc2Imem_addr = 32'h400;
      proc2Dmem_command = LOAD; proc2Dmem_addr = 32'h500;
      settle();
      expect_val($sformatf("starve_d_request_c%0d", c), 64'(exp_grant[c]));
      check(64'(d_request));
      expect_val($sformatf("starve_addr_c%0d", c), exp_grant[c] ? 64'h500 : 64'h400);
      check(64'(proc2mem_addr));
      tick();
    end
    idle(); tick();

    // D store accepted with tag 7: no table entry
    proc2Dmem_command = STORE; proc2Dmem_addr = 32'h600;
    proc2Dmem_data = 64'hCAFE; mem2proc_response = 4'd7;
    settle();
    expect_val("store_cmd", 64'(STORE));      check(64'(proc2mem_command));
    expect_val("store_data", 64'hCAFE);       check(proc2mem_data);
    tick(); idle();
    mem2proc_tag = 4'd7;
    settle();
    expect_val("store_cpl_Itag", 64'd0);      check(64'(Imem2proc_tag));
    expect_val("store_cpl_Dtag", 64'd0);      check(64'(Dmem2proc_tag));
    tick(); idle(); settle();
    expect_val("store_outstanding", 64'd0);   check(64'(outstanding_i));

    // Same-tag completion and reallocation (tag 2: I -> D)
    proc2Imem_command = LOAD; proc2Imem_addr = 32'h700; mem2proc_response = 4'd2;
    tick(); idle(); settle();
    expect_val("tag2_i_outstanding", 64'd1);  check(64'(outstanding_i));
    proc2Dmem_command = LOAD; proc2Dmem_addr = 32'h800;
    mem2proc_response = 4'd2; mem2proc_tag = 4'd2;
    settle();
    expect_val("tag2_swap_Itag", 64'd2);      check(64'(Imem2proc_tag));
    expect_val("tag2_swap_Dtag", 64'd0);      check(64'(Dmem2proc_tag));
    tick(); idle(); settle();
    expect_val("tag2_swap_outstanding", 64'd0); check(64'(outstanding_i));
    mem2proc_tag = 4'd2;
    settle();
    expect_val("tag2_d_cpl_Dtag", 64'd2);     check(64'(Dmem2proc_tag));
    expect_val("tag2_d_cpl_Itag", 64'd0);     check(64'(Imem2proc_tag));
    tick(); idle();
    mem2proc_tag = 4'd2;
    settle();
    expect_val("tag2_stale_Dtag", 64'd0);     check(64'(Dmem2proc_tag));
    expect_val("tag2_stale_Itag", 64'd0);     check(64'(Imem2proc_tag));
    tick(); idle();

    // Overwrite of a valid tag changes owner (tag 6: I -> D)
    proc2Imem_command = LOAD; mem2proc_response = 4'd6;
    tick(); idle(); settle();
    expect_val("tag6_i_outstanding", 64'd1);  check(64'(outstanding_i));
    proc2Dmem_command = LOAD; mem2proc_response = 4'd6;
    tick(); idle(); settle();
    expect_val("tag6_d_outstanding", 64'd0);  check(64'(outstanding_i));
    mem2proc_tag = 4'd6;
    settle();
    expect_val("tag6_cpl_Dtag", 64'd6);       check(64'(Dmem2proc_tag));
    expect_val("tag6_cpl_Itag", 64'd0);       check(64'(Imem2proc_tag));
    tick(); idle();

    // Reset discards outstanding I loads (tags 1 and 4)
    proc2Imem_command = LOAD; mem2proc_response = 4'd1;
    tick();
    proc2Imem_command = LOAD; mem2proc_response = 4'd4;
    tick(); idle(); settle();
    expect_val("pre_rst_outstanding", 64'd2); check(64'(outstanding_i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    expect_val("post_rst_outstanding", 64'd0); check(64'(outstanding_i));
    mem2proc_tag = 4'd4;
    settle();
    expect_val("post_rst_Itag", 64'd0);       check(64'(Imem2proc_tag));
    expect_val("post_rst_Dtag", 64'd0);       check(64'(Dmem2proc_tag));
    tick(); idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
